// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU bus bundle for the ALU issue/writeback stage.
// master = instruction source / ALU / debug side, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_instr;
   logic       ld_en;
   logic [1:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_op;
   logic       alu_en;
   logic [7:0] alu_res;
   logic       alu_c;
   logic       alu_z;
   logic       alu_v;
   logic [2:0] flags;
   logic       done;
   logic       busy;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   modport master (
      output in_valid, in_instr, ld_en, ld_addr, ld_data,
             alu_res, alu_c, alu_z, alu_v, dbg_addr,
      input  in_ready, alu_a, alu_b, alu_op, alu_en, flags, done, busy, dbg_data
   );

   modport slave (
      input  in_valid, in_instr, ld_en, ld_addr, ld_data,
             alu_res, alu_c, alu_z, alu_v, dbg_addr,
      output in_ready, alu_a, alu_b, alu_op, alu_en, flags, done, busy, dbg_data
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around an 8-bit ALU with a 4-entry register file.
// One instruction in flight: IDLE -> ISSUE -> WAIT* -> WB -> IDLE.
// alu_en is high for exactly RES_LAT cycles; the result is sampled in WB.
// Optional macro ALU_FLAGS_ONLY_EN: instr[0]=1 suppresses the register write
// in WB (flags and done still update).
module alu_issue_ctrl #(
   parameter int RES_LAT = 2
) (
   input logic           clk,
   input logic           rst,
   alu_issue_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

   state_t          state;
   logic [3:0][7:0] regs;
   logic [1:0]      rd_q;
   logic [3:0]      cnt;
   logic [7:0]      rd_val;
   logic [7:0]      rs_val;
   logic            wb_wr;

`ifdef ALU_FLAGS_ONLY_EN
   logic            nowb_q;
   assign wb_wr = ~nowb_q;
`else
   assign wb_wr = 1'b1;
`endif

   // Operand read with forwarding of a same-cycle load in IDLE
   always_comb begin
      rd_val = regs[bus.in_instr[4:3]];
      rs_val = regs[bus.in_instr[2:1]];
      if (bus.ld_en && bus.ld_addr == bus.in_instr[4:3]) rd_val = bus.ld_data;
      if (bus.ld_en && bus.ld_addr == bus.in_instr[2:1]) rs_val = bus.ld_data;
   end

   assign bus.dbg_data = regs[bus.dbg_addr];

   // Issue FSM with registered handshake/ALU outputs and register file writes
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         regs         <= '0;
         rd_q         <= 2'd0;
         cnt          <= 4'd0;
`ifdef ALU_FLAGS_ONLY_EN
         nowb_q       <= 1'b0;
`endif
         bus.alu_a    <= 8'h00;
         bus.alu_b    <= 8'h00;
         bus.alu_op   <= 3'b000;
         bus.alu_en   <= 1'b0;
         bus.flags    <= 3'b000;
         bus.done     <= 1'b0;
         bus.busy     <= 1'b0;
         bus.in_ready <= 1'b1;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ld_en) regs[bus.ld_addr] <= bus.ld_data;
               if (bus.in_valid) begin
                  rd_q         <= bus.in_instr[4:3];
`ifdef ALU_FLAGS_ONLY_EN
                  nowb_q       <= bus.in_instr[0];
`endif
                  bus.alu_a    <= rd_val;
                  bus.alu_b    <= rs_val;
                  bus.alu_op   <= bus.in_instr[7:5];
                  bus.alu_en   <= 1'b1;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               cnt <= 4'(RES_LAT - 1);
               if (RES_LAT == 1) begin
                  bus.alu_en <= 1'b0;
                  bus.done   <= 1'b1;
                  state      <= WB;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  bus.alu_en <= 1'b0;
                  bus.done   <= 1'b1;
                  state      <= WB;
               end
            end
            WB: begin
               if (wb_wr) regs[rd_q] <= bus.alu_res;
               bus.flags    <= {bus.alu_c, bus.alu_z, bus.alu_v};
               bus.in_ready <= 1'b1;
               bus.busy     <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model (register array + accept cycle).
module tb_alu_issue_ctrl;
   localparam int RES_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_issue_ctrl_if bus();
   alu_issue_ctrl #(.RES_LAT(RES_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   // Reference ALU: returns {res, c, z, v}
   function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
      logic [8:0] w;
      logic       v;
      v = 1'b0;
      case (op)
         3'd0: w = {1'b0, a & b};
         3'd1: w = {1'b0, a | b};
         3'd2: w = {1'b0, a ^ b};
         3'd3: w = {1'b0, ~a};
         3'd4: begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
         3'd5: begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
         3'd6: w = {1'b0, b};
         default: w = {a, 1'b0};
      endcase
      return {w[7:0], w[8], (w[7:0] == 8'h00), v};
   endfunction

   logic [10:0] alu_out;
   assign alu_out     = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
   assign bus.alu_res = alu_out[10:3];
   assign bus.alu_c   = alu_out[2];
   assign bus.alu_z   = alu_out[1];
   assign bus.alu_v   = alu_out[0];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_r [4];
   logic [2:0] m_flags = 3'b000;
   logic [7:0] m_a = 8'h00, m_b = 8'h00;
   logic [2:0] m_op = 3'b000;
   logic [1:0] m_rd = 2'd0;
   logic       m_nowb = 1'b0;
   bit         m_pend = 1'b0;
   bit         m_live = 1'b0;
   int         m_acc  = 0;
   int         n_acc  = 0;
   int         cyc    = 0;
   int         en_run = 0;
   int         done_cyc = -1;

   // Model advances on each edge from the inputs held during the ending cycle
   always @(posedge clk) begin
      logic [10:0] o;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
         m_flags = 3'b000; m_pend = 1'b0;
         m_a = 8'h00; m_b = 8'h00; m_op = 3'b000;
         m_live = 1'b1;
      end else if (m_live) begin
         if (!m_pend) begin
            if (bus.ld_en) m_r[bus.ld_addr] = bus.ld_data;
            if (bus.in_valid) begin
               m_pend = 1'b1; m_acc = cyc; n_acc++;
               m_rd   = bus.in_instr[4:3];
               m_a    = m_r[bus.in_instr[4:3]];
               m_b    = m_r[bus.in_instr[2:1]];
               m_op   = bus.in_instr[7:5];
               m_nowb = bus.in_instr[0];
            end
         end else if (cyc - m_acc == RES_LAT + 1) begin
            o = alu_f(m_a, m_b, m_op);
`ifdef ALU_FLAGS_ONLY_EN
            if (!m_nowb)
`endif
            m_r[m_rd] = o[10:3];
            m_flags = o[2:0];
            m_pend  = 1'b0;
         end
      end
      cyc++;
   end

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      int  k;
      logic e_en, e_done;
      if (m_live) begin
         k      = cyc - m_acc;
         e_en   = m_pend && k >= 1 && k <= RES_LAT;
         e_done = m_pend && k == RES_LAT + 1;
         chk("in_ready", bus.in_ready, !m_pend);
         chk("busy",     bus.busy,     m_pend);
         chk("alu_en",   bus.alu_en,   e_en);
         chk("done",     bus.done,     e_done);
         chk("alu_a",    bus.alu_a,    m_a);
         chk("alu_b",    bus.alu_b,    m_b);
         chk("alu_op",   bus.alu_op,   m_op);
         chk("flags",    bus.flags,    m_flags);
         chk("dbg_data", bus.dbg_data, m_r[bus.dbg_addr]);
         if (bus.alu_en) en_run++;
         if (bus.done) done_cyc = cyc;
      end
   end

   // ---------------- stimulus ----------------
   int acc_c;

   task automatic tick;
      @(posedge clk); #2;
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
      tick;
      bus.ld_en = 1'b0;
   endtask

   task automatic wait_idle;
      for (int i = 0; i < 50 && !bus.in_ready; i++) tick;
      chk("idle_reached", bus.in_ready, 1'b1);
   endtask

   task automatic send(input logic [7:0] ins);
      bus.in_valid = 1'b1; bus.in_instr = ins;
      tick;
      acc_c = cyc - 1;
      bus.in_valid = 1'b0;
      wait_idle;
   endtask

   task automatic rchk(input string nm, input logic [1:0] a, input logic [7:0] exp);
      bus.dbg_addr = a; #1;
      chk(nm, bus.dbg_data, exp);
   endtask

   initial begin
      int e0, n0;
      bus.in_valid = 1'b0; bus.in_instr = 8'h00;
      bus.ld_en = 1'b0; bus.ld_addr = 2'd0; bus.ld_data = 8'h00;
      bus.dbg_addr = 2'd0;
      rst = 1'b1; tick; tick; rst = 1'b0;

      chk("rst_ready", bus.in_ready, 1'b1);
      chk("rst_busy",  bus.busy,     1'b0);
      chk("rst_en",    bus.alu_en,   1'b0);
      chk("rst_flags", bus.flags,    3'b000);
      for (int i = 0; i < 4; i++) rchk("rst_reg", 2'(i), 8'h00);

      // ADD rd0 rs1: 0x0F + 0x01
      load(2'd0, 8'h0F); load(2'd1, 8'h01);
      e0 = en_run;
      send(8'h82);
      chk("add_en_cycles", en_run - e0, 2);
      chk("add_done_lat",  done_cyc - acc_c, 3);
      rchk("add_r0", 2'd0, 8'h10);
      chk("add_flags", bus.flags, 3'b000);

      // SUB rd0 rs0 -> zero
      send(8'hA0);
      rchk("sub_r0", 2'd0, 8'h00);
      chk("sub_flags", bus.flags, 3'b010);

      // ADD rd2 rs3: 0xFF + 0x01 wraps, carry + zero
      load(2'd2, 8'hFF); load(2'd3, 8'h01);
      send(8'h96);
      rchk("wrap_r2", 2'd2, 8'h00);
      chk("wrap_flags", bus.flags, 3'b110);

      // Held in_valid, two instructions; load during WAIT is dropped
      n0 = n_acc;
      bus.in_valid = 1'b1; bus.in_instr = 8'hC8;
      tick;
      bus.in_instr = 8'h8A;
      tick;
      chk("b2b_ready", bus.in_ready, 1'b0);
      chk("b2b_busy",  bus.busy,     1'b1);
      bus.ld_en = 1'b1; bus.ld_addr = 2'd3; bus.ld_data = 8'hAA;
      tick;
      bus.ld_en = 1'b0;
      tick; tick;
      bus.in_valid = 1'b0;
      wait_idle;
      chk("b2b_accepts", n_acc - n0, 2);
      rchk("b2b_r3", 2'd3, 8'h01);
      chk("b2b_flags", bus.flags, 3'b010);

      // Reset during WAIT
      bus.in_valid = 1'b1; bus.in_instr = 8'h96;
      tick;
      bus.in_valid = 1'b0;
      tick;
      rst = 1'b1; tick; rst = 1'b0;
      @(negedge clk);
      chk("wrst_en",    bus.alu_en,   1'b0);
      chk("wrst_done",  bus.done,     1'b0);
      chk("wrst_ready", bus.in_ready, 1'b1);
      chk("wrst_flags", bus.flags,    3'b000);
      for (int i = 0; i < 4; i++) rchk("wrst_reg", 2'(i), 8'h00);
      tick;

      // SUB rd0 rs1 with nowb bit set
      load(2'd0, 8'h05); load(2'd1, 8'h05);
      send(8'hA3);
`ifdef ALU_FLAGS_ONLY_EN
      rchk("nowb_r0", 2'd0, 8'h05);
`else
      rchk("nowb_r0", 2'd0, 8'h00);
`endif
      chk("nowb_flags", bus.flags, 3'b010);
      chk("nowb_done",  done_cyc - acc_c, 3);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 199) == 0);
         bus.in_valid = ($urandom_range(0, 2) == 0);
         bus.in_instr = 8'($urandom);
         bus.ld_en    = 1'($urandom);
         bus.ld_addr  = 2'($urandom);
         bus.ld_data  = 8'($urandom);
         bus.dbg_addr = 2'($urandom);
         tick;
      end
      rst = 1'b0; bus.in_valid = 1'b0; bus.ld_en = 1'b0;
      repeat (8) tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
